// File: rtl/mult_seq_ctrl.sv
// Sequential shift-add multiplier fed from an internal operand RAM.
// Each operation consumes the pair bank[ptr], bank[ptr+1] and then advances ptr by two.
module mult_seq_ctrl #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic                 start,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [ADDR_W-1:0]    ptr
);

  typedef enum logic [1:0] {IDLE, FETCH, MUL, DONE} state_t;

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(DEPTH - 2);
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(WIDTH - 1);

  state_t               state;
  logic [WIDTH-1:0]     bank [DEPTH];
  logic [ADDR_W-1:0]    ptr_b;
  logic [WIDTH-1:0]     op_a, op_b, mag_a, mag_b;
  logic                 a_signed, b_signed, a_neg, b_neg;
  logic [2*WIDTH-1:0]   acc, mcand, acc_next;
  logic [WIDTH-1:0]     mplier;
  logic                 neg;
  logic [CNT_W-1:0]     step;

  // RAM contents survive reset; reads are asynchronous so a same-edge write yields old data.
  always_ff @(posedge clock) begin
    if (wr_en) bank[wr_addr] <= wr_data;
  end

  always_comb begin
    ptr_b    = (ptr == LAST_IDX) ? '0 : ptr + ADDR_W'(1);
    op_a     = bank[ptr];
    op_b     = bank[ptr_b];
    a_signed = (mode == 2'b01) || (mode == 2'b10);
    b_signed = (mode == 2'b01);
    a_neg    = a_signed & op_a[WIDTH-1];
    b_neg    = b_signed & op_b[WIDTH-1];
    // Magnitude of the most negative value still fits when read back as unsigned.
    mag_a    = a_neg ? -op_a : op_a;
    mag_b    = b_neg ? -op_b : op_b;
    acc_next = mplier[0] ? acc + mcand : acc;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      ptr     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      neg     <= 1'b0;
      step    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          acc    <= '0;
          mcand  <= {{WIDTH{1'b0}}, mag_a};
          mplier <= mag_b;
          neg    <= a_neg ^ b_neg;
          step   <= '0;
          state  <= MUL;
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          step   <= step + CNT_W'(1);
          // Last partial product is folded straight into the result register.
          if (step == LAST_STEP) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= neg ? -acc_next : acc_next;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          ptr   <= (ptr == LAST_PAIR) ? '0 : ptr + ADDR_W'(2);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
